// File: rtl/board_arbiter.sv
// Board-memory arbiter: display row reads, cursor-cell toggles (done as atomic
// read-modify-write) and generation-engine accesses share one single-port row RAM.
module board_arbiter #(
    parameter int ROWS = 48,
    parameter int COLS = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            freeze,
    input  logic            disp_req,
    input  logic [5:0]      disp_addr,
    output logic            disp_gnt,
    output logic            disp_rvalid,
    input  logic            edit_req,
    input  logic [5:0]      edit_x,
    input  logic [5:0]      edit_y,
    output logic            edit_gnt,
    input  logic            gen_req,
    input  logic            gen_we,
    input  logic [5:0]      gen_addr,
    input  logic [COLS-1:0] gen_wdata,
    output logic            gen_gnt,
    output logic            gen_rvalid,
    output logic [COLS-1:0] rd_data,
    output logic [5:0]      mem_addr,
    output logic            mem_we,
    output logic [COLS-1:0] mem_wdata,
    input  logic [COLS-1:0] mem_rdata
);

    typedef enum logic {IDLE = 1'b0, RMW_WR = 1'b1} state_t;
    typedef enum logic {PTR_EDIT = 1'b0, PTR_GEN = 1'b1} ptr_t;

    localparam int unsigned ROWS_U = ROWS;

    function automatic logic in_range(input logic [5:0] a);
        return 32'(a) < ROWS_U;
    endfunction

    state_t          state_q, state_d;
    ptr_t            ptr_q, ptr_d;
    logic            disp_gnt_d, edit_gnt_d, gen_gnt_d;
    logic            disp_rvalid_d, gen_rvalid_d;
    logic [5:0]      mem_addr_d;
    logic            mem_we_d;
    logic [COLS-1:0] wdata_q, wdata_d;
    logic [COLS-1:0] mask_q, mask_d;
    logic            rmw_wr_q, rmw_wr_d;
    logic            rd_pass_q, rd_pass_d;
    logic            acc_rd_q, acc_rd_d;
    logic            acc_in_range_q, acc_in_range_d;
    logic            disp_ok, edit_ok, gen_ok;

    // A port is ineligible on the edge that ends its own grant cycle.
    assign disp_ok = disp_req && !disp_gnt;
    assign edit_ok = edit_req && !edit_gnt;
    assign gen_ok  = gen_req && !gen_gnt && !freeze;

    // The toggle write data depends on the RAM read that lands in the write cycle.
    assign mem_wdata = rmw_wr_q ? (mem_rdata ^ mask_q) : wdata_q;
    assign rd_data   = rd_pass_q ? mem_rdata : '0;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        disp_gnt_d     = 1'b0;
        edit_gnt_d     = 1'b0;
        gen_gnt_d      = 1'b0;
        mem_addr_d     = mem_addr;
        mem_we_d       = 1'b0;
        wdata_d        = wdata_q;
        mask_d         = mask_q;
        rmw_wr_d       = 1'b0;
        acc_rd_d       = acc_rd_q;
        acc_in_range_d = acc_in_range_q;

        disp_rvalid_d  = disp_gnt;
        gen_rvalid_d   = gen_gnt && acc_rd_q;
        rd_pass_d      = (disp_gnt || (gen_gnt && acc_rd_q)) && acc_in_range_q;

        case (state_q)
            IDLE: begin
                if (disp_ok) begin
                    disp_gnt_d     = 1'b1;
                    mem_addr_d     = disp_addr;
                    acc_rd_d       = 1'b1;
                    acc_in_range_d = in_range(disp_addr);
                end else if (edit_ok && (!gen_ok || ptr_q == PTR_EDIT)) begin
                    edit_gnt_d     = 1'b1;
                    mem_addr_d     = edit_y;
                    mask_d         = {{(COLS-1){1'b0}}, 1'b1} << edit_x;
                    acc_rd_d       = 1'b0;
                    acc_in_range_d = in_range(edit_y);
                    ptr_d          = PTR_GEN;
                    state_d        = RMW_WR;
                end else if (gen_ok) begin
                    gen_gnt_d      = 1'b1;
                    mem_addr_d     = gen_addr;
                    mem_we_d       = gen_we && in_range(gen_addr);
                    wdata_d        = gen_wdata;
                    acc_rd_d       = !gen_we;
                    acc_in_range_d = in_range(gen_addr);
                    ptr_d          = PTR_EDIT;
                end
            end
            RMW_WR: begin
                mem_we_d = acc_in_range_q;
                rmw_wr_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            ptr_q          <= PTR_EDIT;
            disp_gnt       <= 1'b0;
            edit_gnt       <= 1'b0;
            gen_gnt        <= 1'b0;
            disp_rvalid    <= 1'b0;
            gen_rvalid     <= 1'b0;
            mem_addr       <= '0;
            mem_we         <= 1'b0;
            wdata_q        <= '0;
            mask_q         <= '0;
            rmw_wr_q       <= 1'b0;
            rd_pass_q      <= 1'b0;
            acc_rd_q       <= 1'b0;
            acc_in_range_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            disp_gnt       <= disp_gnt_d;
            edit_gnt       <= edit_gnt_d;
            gen_gnt        <= gen_gnt_d;
            disp_rvalid    <= disp_rvalid_d;
            gen_rvalid     <= gen_rvalid_d;
            mem_addr       <= mem_addr_d;
            mem_we         <= mem_we_d;
            wdata_q        <= wdata_d;
            mask_q         <= mask_d;
            rmw_wr_q       <= rmw_wr_d;
            rd_pass_q      <= rd_pass_d;
            acc_rd_q       <= acc_rd_d;
            acc_in_range_q <= acc_in_range_d;
        end
    end

endmodule

// File: doc/board_arbiter.md
# board_arbiter

Fixed-priority / round-robin arbiter sharing the single-port 48-row x 64-bit board memory among three requesters: VGA display row fetch, cursor cell edit, and generation-update engine. Sits between the game FSM, cursor logic and display on one side and the board row RAM on the other. Cursor edits are executed internally as atomic read-modify-write toggles. One memory access per cycle, all outputs registered.

## Interface
- ROWS, 48, board rows; addresses >= ROWS are out of range
- COLS, 64, bits per row word (bit x = cell column x)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- freeze  in  1  1 = game frozen; gen requests not granted (synchronous to clk)
- disp_req  in  1  display row-read request, held until disp_gnt
- disp_addr  in  6  display row
- disp_gnt  out  1  one-cycle grant pulse
- disp_rvalid  out  1  rd_data valid for display
- edit_req  in  1  cell-toggle request, held until edit_gnt
- edit_x  in  6  cell column
- edit_y  in  6  cell row
- edit_gnt  out  1  one-cycle grant pulse
- gen_req  in  1  engine access request, held until gen_gnt
- gen_we  in  1  1 = write gen_wdata, 0 = read
- gen_addr  in  6  engine row
- gen_wdata  in  64  engine write row
- gen_gnt  out  1  one-cycle grant pulse
- gen_rvalid  out  1  rd_data valid for engine
- rd_data  out  64  shared read-return bus
- mem_addr  out  6  RAM row address
- mem_we  out  1  RAM write enable
- mem_wdata  out  64  RAM write data
- mem_rdata  in  64  RAM read data, valid one cycle after read command

## Operation
- States: IDLE, RMW_WR. Only IDLE issues grants.
- IDLE arbitration at each edge, among requests sampled high: disp highest; edit vs gen round-robin (pointer toggles to the other port after either is granted; reset pointer favours edit). gen eligible only when freeze=0.
- A port granted in cycle G is ineligible at the edge ending G (req still high from requester); eligible again from G+1 edge.
- Grant cycle G: gnt pulse, mem_addr/mem_we/mem_wdata carry the granted access in the same cycle.
- disp: read of disp_addr. gen: read or write per gen_we.
- edit: G issues read of edit_y, state -> RMW_WR; G+1 issues write edit_y with mem_rdata XOR (1<<edit_x), state -> IDLE. edit_x/edit_y must be held stable through G+1. No grant in G+1.
- Reads: rd_data = mem_rdata and matching rvalid high in G+1 (one cycle). RMW read returns no rvalid.
- Out-of-range row (addr >= ROWS): granted normally; mem_we forced 0; rvalid returned with rd_data = 0; edit out of range performs no write.
- freeze rising while gen pending: gen_req held, not granted until freeze=0. A gen access already granted completes.

## Timing
- Reset (rst=0): all gnt, rvalid, mem_we = 0; mem_addr, mem_wdata, rd_data = 0; state IDLE; pointer = edit. Reset during RMW_WR abandons the write (cell unchanged).
- Grant latency: req high before edge E -> earliest gnt in cycle after E (1 cycle).
- disp worst-case latency 2 cycles (arrives while RMW_WR occupies memory).
- Read data latency: 1 cycle after gnt.
- Simultaneous disp+edit+gen: disp, then round-robin winner, then loser; no port starves while disp rate <= 1 per 2 cycles.
- Throughput: 1 access/cycle; edit costs 2 cycles.

## Test plan
- Reset: rst=0 mid-RMW -> all outputs 0, row unchanged; after release, first edit+gen contention grants edit.
- Edit toggle: row 5 = 0, edit_req x=3 y=5 -> edit_gnt at G, write at G+1 row 5 = 0x8; repeat -> row 5 = 0.
- Contention: disp, edit, gen all held from one edge -> grants disp (G), edit (G+1), RMW write (G+2), gen (G+3).
- Round-robin: edit and gen held continuously for 6 grants -> alternate edit, gen, edit, gen... with no back-to-back same port.
- Freeze: freeze=1, gen_req held 20 cycles -> no gen_gnt; freeze=0 -> gen_gnt next cycle; gen write row 10 = 0xFFFF then read -> rd_data 0xFFFF, gen_rvalid 1 cycle after gnt.
- Out of range: disp_addr=50 -> disp_gnt, disp_rvalid with rd_data=0; edit y=48 -> mem_we never asserted.
